// File: rtl/nn_cfg_pkg.sv
// Shared constants for the neuron configuration path: word layout,
// header field positions and loader FSM encoding.
package nn_cfg_pkg;

  localparam int DATA_WIDTH = 32;

  // Header word layout: [31:24] layer, [23:16] neuron, [15:0] weight count
  localparam int LAYER_MSB  = 31;
  localparam int LAYER_LSB  = 24;
  localparam int NEURON_MSB = 23;
  localparam int NEURON_LSB = 16;
  localparam int COUNT_MSB  = 15;
  localparam int COUNT_LSB  = 0;

  localparam int LAYER_W  = LAYER_MSB - LAYER_LSB + 1;
  localparam int NEURON_W = NEURON_MSB - NEURON_LSB + 1;
  localparam int COUNT_W  = COUNT_MSB - COUNT_LSB + 1;

  typedef struct packed {
    logic [LAYER_W-1:0]  layer;
    logic [NEURON_W-1:0] neuron;
    logic [COUNT_W-1:0]  count;
  } hdr_fields_t;

  // Loader FSM encoding
  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_WGT  = 2'd1;
  localparam logic [1:0] ST_BIAS = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/neuron_weight_loader_if.sv
// Host-side valid/ready word stream feeding the weight loader.
interface neuron_weight_loader_if;
  import nn_cfg_pkg::*;

  logic [DATA_WIDTH-1:0] cfgData;
  logic                  cfgValid;
  logic                  cfgReady;

  modport master (output cfgData, output cfgValid, input cfgReady);
  modport slave  (input cfgData, input cfgValid, output cfgReady);
endinterface

// File: rtl/cfg_header_decode.sv
// Combinational header field extraction and legality check.
module cfg_header_decode
  import nn_cfg_pkg::*;
#(
  parameter int NUM_LAYERS  = 4,
  parameter int MAX_WEIGHTS = 784
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  output hdr_fields_t           fields_o,
  output logic                  legal_o
);

  assign fields_o.layer  = word_i[LAYER_MSB:LAYER_LSB];
  assign fields_o.neuron = word_i[NEURON_MSB:NEURON_LSB];
  assign fields_o.count  = word_i[COUNT_MSB:COUNT_LSB];

  // A record must carry at least one weight, no more than a neuron holds,
  // and address an existing layer.
  always_comb begin
    legal_o = 1'b1;
    if (fields_o.count == '0)                          legal_o = 1'b0;
    if (32'(fields_o.count) > 32'(MAX_WEIGHTS))        legal_o = 1'b0;
    if (32'(fields_o.layer) >= 32'(NUM_LAYERS))        legal_o = 1'b0;
  end

endmodule

// File: rtl/neuron_weight_loader.sv
// Parses the host config stream into header / weight burst / bias records
// and broadcasts tagged weight and bias strobes to the neuron array.
module neuron_weight_loader
  import nn_cfg_pkg::*;
#(
  parameter int NUM_LAYERS    = 4,
  parameter int MAX_WEIGHTS   = 784,
  parameter int TOTAL_NEURONS = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  neuron_weight_loader_if.slave cfg,
  output logic                  weightValid_o,
  output logic [31:0]           weightValue_o,
  output logic                  biasValid_o,
  output logic [31:0]           biasValue_o,
  output logic [31:0]           configLayerNumber_o,
  output logic [31:0]           configNeuronNumber_o,
  output logic                  neuronDone_o,
  output logic [CNT_WIDTH-1:0]  loadedCount_o,
  output logic                  allDone_o,
  output logic                  err_o
);

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  remain_q, remain_d;
  logic                  ready_q, ready_d;
  logic                  wvalid_q, wvalid_d;
  logic [31:0]           wvalue_q, wvalue_d;
  logic                  bvalid_q, bvalid_d;
  logic [31:0]           bvalue_q, bvalue_d;
  logic [LAYER_W-1:0]    layer_q, layer_d;
  logic [NEURON_W-1:0]   neuron_q, neuron_d;
  logic                  ndone_q, ndone_d;
  logic [CNT_WIDTH-1:0]  loaded_q, loaded_d;
  logic                  alldone_q, alldone_d;
  logic                  err_q, err_d;

  hdr_fields_t hdr;
  logic        hdr_legal;
  logic        accept;

  cfg_header_decode #(
    .NUM_LAYERS  (NUM_LAYERS),
    .MAX_WEIGHTS (MAX_WEIGHTS)
  ) u_hdr (
    .word_i   (cfg.cfgData),
    .fields_o (hdr),
    .legal_o  (hdr_legal)
  );

  assign accept = cfg.cfgValid && ready_q;

  // Next-state: record parser, strobe generation and completion bookkeeping
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    ready_d   = 1'b1;
    wvalid_d  = 1'b0;
    wvalue_d  = wvalue_q;
    bvalid_d  = 1'b0;
    bvalue_d  = bvalue_q;
    layer_d   = layer_q;
    neuron_d  = neuron_q;
    ndone_d   = 1'b0;
    loaded_d  = loaded_q;
    err_d     = err_q;
    case (state_q)
      ST_HDR: begin
        if (accept) begin
          if (!hdr_legal) begin
            err_d = 1'b1;
          end else begin
            layer_d  = hdr.layer;
            neuron_d = hdr.neuron;
            remain_d = CNT_WIDTH'(hdr.count);
            state_d  = ST_WGT;
            // The network is already complete, so this record is surplus
            if (alldone_q) err_d = 1'b1;
          end
        end
      end
      ST_WGT: begin
        if (accept) begin
          wvalid_d = 1'b1;
          wvalue_d = cfg.cfgData;
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_WIDTH'(1)) state_d = ST_BIAS;
        end
      end
      ST_BIAS: begin
        if (accept) begin
          bvalid_d = 1'b1;
          bvalue_d = cfg.cfgData;
          ndone_d  = 1'b1;
          if (loaded_q != '1) loaded_d = loaded_q + 1'b1;
          state_d  = ST_GAP;
          // One dead cycle keeps the tag steady under the bias strobe
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
    alldone_d = alldone_q || (32'(loaded_d) >= 32'(TOTAL_NEURONS));
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_HDR;
      remain_q  <= '0;
      ready_q   <= 1'b1;
      wvalid_q  <= 1'b0;
      wvalue_q  <= '0;
      bvalid_q  <= 1'b0;
      bvalue_q  <= '0;
      layer_q   <= '0;
      neuron_q  <= '0;
      ndone_q   <= 1'b0;
      loaded_q  <= '0;
      alldone_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      ready_q   <= ready_d;
      wvalid_q  <= wvalid_d;
      wvalue_q  <= wvalue_d;
      bvalid_q  <= bvalid_d;
      bvalue_q  <= bvalue_d;
      layer_q   <= layer_d;
      neuron_q  <= neuron_d;
      ndone_q   <= ndone_d;
      loaded_q  <= loaded_d;
      alldone_q <= alldone_d;
      err_q     <= err_d;
    end
  end

  assign cfg.cfgReady          = ready_q;
  assign weightValid_o         = wvalid_q;
  assign weightValue_o         = wvalue_q;
  assign biasValid_o           = bvalid_q;
  assign biasValue_o           = bvalue_q;
  assign configLayerNumber_o   = 32'(layer_q);
  assign configNeuronNumber_o  = 32'(neuron_q);
  assign neuronDone_o          = ndone_q;
  assign loadedCount_o         = loaded_q;
  assign allDone_o             = alldone_q;
  assign err_o                 = err_q;

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Bench for neuron_weight_loader: record-level expectation queue built from
// the stimulus, checked against the strobes on every cycle.
module tb_neuron_weight_loader;
  import nn_cfg_pkg::*;

  localparam int NL = 4;
  localparam int MW = 784;
  localparam int TN = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neuron_weight_loader_if cfg_if();

  logic          weightValid_o, biasValid_o, neuronDone_o, allDone_o, err_o;
  logic [31:0]   weightValue_o, biasValue_o, configLayerNumber_o, configNeuronNumber_o;
  logic [CW-1:0] loadedCount_o;

  neuron_weight_loader #(
    .NUM_LAYERS(NL), .MAX_WEIGHTS(MW), .TOTAL_NEURONS(TN), .CNT_WIDTH(CW)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .cfg                  (cfg_if.slave),
    .weightValid_o        (weightValid_o),
    .weightValue_o        (weightValue_o),
    .biasValid_o          (biasValid_o),
    .biasValue_o          (biasValue_o),
    .configLayerNumber_o  (configLayerNumber_o),
    .configNeuronNumber_o (configNeuronNumber_o),
    .neuronDone_o         (neuronDone_o),
    .loadedCount_o        (loadedCount_o),
    .allDone_o            (allDone_o),
    .err_o                (err_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_bias;
    logic [31:0] val;
    logic [31:0] layer;
    logic [31:0] neuron;
    logic [31:0] loaded;
    bit          done;
  } ev_t;

  ev_t         evq[$];
  int          exp_loaded = 0;
  bit          exp_done   = 0;
  bit          exp_err    = 0;
  logic [31:0] last_w = '0;
  logic [31:0] last_b = '0;
  bit          mon_en = 0;
  bit          acc_prev = 0;
  logic [31:0] acc_word = '0;
  logic [31:0] wbuf [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: every strobe must match the next expected event and
  // follow an acceptance by exactly one cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      chk("single_strobe", 32'(weightValid_o & biasValid_o), 32'd0);
      chk("done_with_bias", 32'(neuronDone_o), 32'(biasValid_o));
      chk("ready_gap", 32'(cfg_if.cfgReady), 32'(!biasValid_o));
      if (weightValid_o || biasValid_o) begin
        chk("strobe_latency", 32'(acc_prev), 32'd1);
        if (evq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual=w%0d/b%0d required=none t=%0t",
                   weightValid_o, biasValid_o, $time);
        end else begin
          e = evq.pop_front();
          chk("strobe_kind", 32'(biasValid_o), 32'(e.is_bias));
          chk("strobe_value", biasValid_o ? biasValue_o : weightValue_o, e.val);
          chk("value_vs_word", biasValid_o ? biasValue_o : weightValue_o, acc_word);
          chk("tag_layer", configLayerNumber_o, e.layer);
          chk("tag_neuron", configNeuronNumber_o, e.neuron);
          chk("loaded_at_strobe", 32'(loadedCount_o), e.loaded);
          chk("alldone_at_strobe", 32'(allDone_o), 32'(e.done));
          if (e.is_bias) last_b = e.val;
          else           last_w = e.val;
        end
      end
      chk("weight_hold", weightValue_o, last_w);
      chk("bias_hold", biasValue_o, last_b);
      acc_prev = cfg_if.cfgValid && cfg_if.cfgReady && !rst;
      acc_word = cfg_if.cfgData;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cfg_if.cfgValid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("queue_drained", 32'(evq.size()), 32'd0);
    evq.delete();
    last_w = '0; last_b = '0;
    exp_loaded = 0; exp_done = 0; exp_err = 0;
    chk("rst_wvalid", 32'(weightValid_o), 0);
    chk("rst_bvalid", 32'(biasValid_o), 0);
    chk("rst_wvalue", weightValue_o, 0);
    chk("rst_bvalue", biasValue_o, 0);
    chk("rst_layer", configLayerNumber_o, 0);
    chk("rst_neuron", configNeuronNumber_o, 0);
    chk("rst_ndone", 32'(neuronDone_o), 0);
    chk("rst_loaded", 32'(loadedCount_o), 0);
    chk("rst_alldone", 32'(allDone_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ready", 32'(cfg_if.cfgReady), 1);
  endtask

  task automatic send(input logic [31:0] w, input int stall);
    int bound;
    cfg_if.cfgValid = 1'b0;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    cfg_if.cfgValid = 1'b1;
    cfg_if.cfgData  = w;
    bound = 0;
    while (!cfg_if.cfgReady && bound < 50) begin
      @(posedge clk);
      #1;
      bound++;
    end
    if (!cfg_if.cfgReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 t=%0t", $time);
    end
    @(posedge clk);
    #1;
    cfg_if.cfgValid = 1'b0;
  endtask

  // Sends one record; weights come from wbuf (randomised unless keep set)
  task automatic send_record(input int layer, input int neuron, input int count,
                             input logic [31:0] bias, input int smin, input int smax,
                             input bit keep);
    logic [31:0] hdr;
    bit legal;
    ev_t e;
    hdr   = {layer[7:0], neuron[7:0], count[15:0]};
    legal = (count != 0) && (count <= MW) && (layer < NL);
    if (!keep) for (int i = 0; i < count && i < 1024; i++) wbuf[i] = $urandom;
    $display("record layer=%0d neuron=%0d count=%0d legal=%0d", layer, neuron, count, legal);
    if (legal) begin
      if (exp_done) exp_err = 1;
      for (int i = 0; i < count; i++) begin
        e = '{0, wbuf[i], layer, neuron, exp_loaded, exp_done};
        evq.push_back(e);
      end
      if (exp_loaded < 65535) exp_loaded++;
      exp_done = exp_done || (exp_loaded >= TN);
      e = '{1, bias, layer, neuron, exp_loaded, exp_done};
      evq.push_back(e);
    end else begin
      exp_err = 1;
    end
    send(hdr, $urandom_range(smax, smin));
    if (legal) begin
      for (int i = 0; i < count; i++) send(wbuf[i], $urandom_range(smax, smin));
      send(bias, $urandom_range(smax, smin));
    end
  endtask

  task automatic checkpoint(input string name, input int eloaded, input int edone, input int eerr);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_loaded"}, 32'(loadedCount_o), eloaded);
    chk({name, "_alldone"}, 32'(allDone_o), edone);
    chk({name, "_err"}, 32'(err_o), eerr);
    chk({name, "_ready"}, 32'(cfg_if.cfgReady), 1);
    chk({name, "_pending"}, 32'(evq.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.cfgValid = 1'b0;
    cfg_if.cfgData  = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
    do_reset();

    // Single back-to-back record
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    send_record(1, 2, 3, 32'h100, 0, 0, 1);
    checkpoint("single", 1, 0, 0);
    chk("single_layer", configLayerNumber_o, 1);
    chk("single_neuron", configNeuronNumber_o, 2);
    chk("single_wlast", weightValue_o, 32'hC);
    chk("single_blast", biasValue_o, 32'h100);

    // Same record with a one-cycle valid gap before every word
    do_reset();
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    send_record(1, 2, 3, 32'h100, 1, 1, 1);
    checkpoint("stall", 1, 0, 0);

    // Illegal headers, then legal records including the largest count
    do_reset();
    send_record(0, 0, 0, 32'h0, 0, 0, 0);
    checkpoint("ill_c0", 0, 0, 1);
    send_record(NL, 0, 1, 32'h0, 0, 0, 0);
    checkpoint("ill_layer", 0, 0, 1);
    send_record(1, 0, MW + 1, 32'h0, 0, 0, 0);
    checkpoint("ill_big", 0, 0, 1);
    send_record(2, 3, MW, 32'h5555, 0, 0, 0);
    checkpoint("max_cnt", 1, 0, 1);

    // Full load of TN records, then a surplus record
    do_reset();
    send_record(0, 0, 1, 32'h11, 0, 0, 0);
    send_record(0, 1, 2, 32'h22, 0, 0, 0);
    checkpoint("full", 2, 1, 0);
    send_record(1, 0, 1, 32'h33, 0, 0, 0);
    checkpoint("extra", 3, 1, 1);

    // Reset after 2 of 5 weights
    do_reset();
    begin
      ev_t e;
      $display("record layer=2 neuron=5 count=5 legal=1 (abandoned)");
      wbuf[0] = $urandom; wbuf[1] = $urandom;
      e = '{0, wbuf[0], 2, 5, 0, 0}; evq.push_back(e);
      e = '{0, wbuf[1], 2, 5, 0, 0}; evq.push_back(e);
      send({8'd2, 8'd5, 16'd5}, 0);
      send(wbuf[0], 0);
      send(wbuf[1], 0);
    end
    do_reset();
    send_record(3, 7, 1, 32'h77, 0, 0, 0);
    checkpoint("post_rst", 1, 0, 0);
    chk("post_rst_layer", configLayerNumber_o, 3);
    chk("post_rst_neuron", configNeuronNumber_o, 7);

    // Randomised records, many back-to-back
    do_reset();
    for (int r = 0; r < 24; r++) begin
      int cnt, sel, smax;
      sel  = $urandom_range(9, 0);
      cnt  = (sel == 9) ? MW + 1 : sel;
      smax = ($urandom_range(1, 0) == 0) ? 0 : 2;
      send_record($urandom_range(NL, 0), $urandom_range(255, 0), cnt, $urandom, 0, smax, 0);
    end
    checkpoint("random", exp_loaded, exp_done, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
